// File: rtl/jk_pkg.sv
// Shared types and constants for the JK flip-flop bank driver.
// Defines the FSM state encoding and the excitation mode select values.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic MODE_SR  = 1'b0;
  localparam logic MODE_TGL = 1'b1;

endpackage

// File: rtl/jk_excite.sv
// One-bit JK excitation: picks the J/K pair that moves q to tq on the next edge.
// In set/reset style a differing bit is driven as set or reset; in toggle style it is toggled.
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic tq,
  input  logic mode,
  output logic j,
  output logic k
);

  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (q != tq) begin
      if (mode == MODE_TGL) begin
        j = 1'b1;
        k = 1'b1;
      end else begin
        j = tq;
        k = ~tq;
      end
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a requested value: one drive cycle, one check
// cycle, and a bounded number of re-drives before reporting an error.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             mode,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  state_t           state;
  logic [WIDTH-1:0] tgt_l;
  logic             mode_l;
  logic [RW-1:0]    cnt;

  logic [WIDTH-1:0] ex_tgt;
  logic             ex_mode;
  logic [WIDTH-1:0] ex_j;
  logic [WIDTH-1:0] ex_k;

  // In IDLE the excitation must see the incoming request, since it is registered at the start edge.
  assign ex_tgt  = (state == IDLE) ? target : tgt_l;
  assign ex_mode = (state == IDLE) ? mode   : mode_l;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ex
    jk_excite u_ex (
      .q    (q_fb[i]),
      .tq   (ex_tgt[i]),
      .mode (ex_mode),
      .j    (ex_j[i]),
      .k    (ex_k[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tgt_l  <= '0;
      mode_l <= 1'b0;
      cnt    <= '0;
      j      <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      j    <= '0;
      k    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tgt_l  <= target;
            mode_l <= mode;
            cnt    <= '0;
            j      <= ex_j;
            k      <= ex_k;
            busy   <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == tgt_l) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt < RMAX) begin
            cnt   <= cnt + RW'(1);
            j     <= ex_j;
            k     <= ex_k;
            state <= DRIVE;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a JK bank with stuck-at-0 injection, a transaction-level
// reference that predicts every output cycle, directed scenarios and random traffic.
module tb_jk_bank_driver;

  localparam int W  = 4;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] target = '0;
  logic         mode = 1'b0;
  logic [W-1:0] j, k;
  logic         busy, done, err;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck = '0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // expected {j, k, busy, done, err} for the current cycle, and the cycles queued after it
  logic [2*W+2:0] cur = '0;
  logic [2*W+2:0] expq[$];

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .mode   (mode),
    .q_fb   (bank),
    .j      (j),
    .k      (k),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Flip-flop bank: J/K semantics per bit, with stuck bits pinned to 0; not reset by rst.
  always_ff @(posedge clk) begin
    if (load_en) bank <= load_val & ~stuck;
    else         bank <= ((j & ~bank) | (~k & bank)) & ~stuck;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] excite(input logic [W-1:0] q, input logic [W-1:0] t,
                                            input logic m);
    logic [W-1:0] diff;
    diff = q ^ t;
    if (m) return {diff, diff};
    return {diff & t, diff & ~t};
  endfunction

  // Whole request outcome: each drive brings every non-stuck bit to the target.
  task automatic build(input logic [W-1:0] b0, input logic [W-1:0] t, input logic m);
    logic [W-1:0] q;
    logic [W-1:0] after;
    q = b0;
    for (int a = 0; a <= MR; a++) begin
      expq.push_back({excite(q, t, m), 3'b100});
      expq.push_back({{2*W{1'b0}}, 3'b100});
      after = t & ~stuck;
      if (after == t) begin
        expq.push_back({{2*W{1'b0}}, 3'b010});
        break;
      end
      if (a == MR) begin
        expq.push_back({{2*W{1'b0}}, 3'b001});
        break;
      end
      q = after;
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        expq.delete();
        cur = '0;
      end else begin
        logic accept;
        accept = start && !cur[2];
        if (expq.size() > 0) cur = expq.pop_front();
        else cur = '0;
        if (accept) begin
          build(bank, target, mode);
          cur = expq.pop_front();
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("cycle_outputs", 32'({j, k, busy, done, err}), 32'(cur));
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic load_bank(input logic [W-1:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Returns at the negedge right after the start edge S.
  task automatic do_start(input logic [W-1:0] t, input logic m);
    @(negedge clk);
    start  = 1'b1;
    target = t;
    mode   = m;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cur != '0 || expq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("idle_timeout", 32'(n), 32'(0));
  endtask

  initial begin : stim
    int d0, e0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_j", 32'(j), 32'(0));
    check("reset_busy", 32'({busy, done, err}), 32'(0));
    rst = 1'b1;

    // set/reset style
    load_bank(4'b0000);
    d0 = done_cnt; e0 = err_cnt;
    do_start(4'b1010, 1'b0);
    check("sr_j", 32'(j), 32'(4'b1010));
    check("sr_k", 32'(k), 32'(4'b0000));
    repeat (2) @(negedge clk);
    #1;
    check("sr_done", 32'(done), 32'(1));
    check("sr_bank", 32'(bank), 32'(4'b1010));
    check("sr_err_none", 32'(err_cnt - e0), 32'(0));
    wait_idle();

    // toggle style
    load_bank(4'b1100);
    do_start(4'b0110, 1'b1);
    check("tgl_jk", 32'({j, k}), 32'(8'b1010_1010));
    repeat (2) @(negedge clk);
    #1;
    check("tgl_done", 32'(done), 32'(1));
    check("tgl_bank", 32'(bank), 32'(4'b0110));
    wait_idle();

    // nothing to change
    load_bank(4'b0101);
    do_start(4'b0101, 1'b0);
    check("same_jk", 32'({j, k, busy}), 32'(9'b0000_0000_1));
    repeat (2) @(negedge clk);
    #1;
    check("same_done", 32'(done), 32'(1));
    check("same_bank", 32'(bank), 32'(4'b0101));
    wait_idle();

    // stuck bit 0: three drives, then err at S+6
    stuck = 4'b0001;
    load_bank(4'b0000);
    d0 = done_cnt; e0 = err_cnt;
    do_start(4'b0001, 1'b0);
    check("stuck_j0", 32'(j), 32'(4'b0001));
    repeat (2) @(negedge clk);
    check("stuck_j1", 32'(j), 32'(4'b0001));
    repeat (2) @(negedge clk);
    check("stuck_j2", 32'(j), 32'(4'b0001));
    repeat (2) @(negedge clk);
    #1;
    check("stuck_err", 32'(err), 32'(1));
    @(negedge clk);
    check("stuck_err_once", 32'(err_cnt - e0), 32'(1));
    check("stuck_no_done", 32'(done_cnt - d0), 32'(0));
    stuck = '0;
    wait_idle();

    // reset during DRIVE
    load_bank(4'b0000);
    d0 = done_cnt; e0 = err_cnt;
    do_start(4'b1111, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async", 32'({j, k, busy}), 32'(0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'(0));
    check("rst_bank_held", 32'(bank), 32'(4'b0000));

    // normal completion afterwards, with start pulses while busy ignored
    d0 = done_cnt;
    do_start(4'b1111, 1'b0);
    start = 1'b1; target = 4'b0011; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("after_rst_done", 32'(done), 32'(1));
    check("after_rst_bank", 32'(bank), 32'(4'b1111));
    repeat (4) @(negedge clk);
    check("busy_start_one_done", 32'(done_cnt - d0), 32'(1));

    // randomized traffic in chunks, each with its own stuck mask
    for (int c = 0; c < 12; c++) begin
      wait_idle();
      stuck = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      load_bank(W'($urandom));
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        start  = ($urandom_range(0, 3) == 0);
        target = W'($urandom);
        mode   = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    stuck = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Initiator side of the JK flip-flop interface: it drives the J/K lines of a WIDTH-bit bank of positive-edge JK flip-flops so that the bank reaches a requested target value.
- Per-bit J/K excitation is computed from the bank's q feedback. The block drives for one cycle, verifies the result, and retries a bounded number of times.
- It sits between a control FSM (start/target/done/err handshake) and the flip-flop bank. All of them share clk and rst.

Parameters:
- WIDTH, 4, number of bank bits driven
- MAX_RETRY, 2, re-drive attempts after a failed check (0 = no retry)

Ports:
- clk  input  1  clock; the block and the driven bank both act on the rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request pulse; sampled only in IDLE
- target  input  WIDTH  requested bank value; latched with start
- mode  input  1  encoding select, latched with start: 0 = set/reset style, 1 = toggle style
- q_fb  input  WIDTH  q outputs of the bank
- j  output  WIDTH  J drive to the bank (registered)
- k  output  WIDTH  K drive to the bank (registered)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse: bank equals target
- err  output  1  one-cycle pulse: retries exhausted and bank still differs

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state to IDLE
  - j, k, done, err and busy to 0
  - the latched target, latched mode and retry count to 0
- Reset mid-operation drops j/k to 0 immediately, which holds the bank. No done or err is produced for the aborted request.
- Excitation per bit i, with tq = latched target[i] and q = q_fb[i]:
  - q==tq: j=0, k=0 (hold), in both modes
  - q=0, tq=1: mode0 gives j=1, k=0; mode1 gives j=1, k=1
  - q=1, tq=0: mode0 gives j=0, k=1; mode1 gives j=1, k=1
- IDLE:
  - start=1 at an edge: latch target and mode, clear the retry count.
  - At the same edge, register j/k from the excitation of the incoming target/mode against q_fb, then go to DRIVE.
- DRIVE (exactly one cycle):
  - j/k are stable for the whole cycle; the bank samples them at the next edge.
  - At that edge, j/k return to 0, then go to CHECK.
- CHECK (one cycle):
  - Compare q_fb with the latched target at the edge.
  - Match: done=1 for one cycle, go to IDLE.
  - Mismatch with retry count < MAX_RETRY: increment the count, re-register j/k from the current q_fb, go to DRIVE.
  - Mismatch with retry count == MAX_RETRY: err=1 for one cycle, go to IDLE.
- Latency without retries: done is high in the cycle after edge S+2, where S is the start edge. Each retry adds 2 cycles.
- Boundary conditions:
  - start while busy is ignored, and target/mode changes while busy have no effect.
  - start in the same cycle as a done/err pulse: the FSM is already in IDLE, so the request is accepted. Done/err still pulse exactly once.
  - target equal to q_fb at start: DRIVE is issued with j=k=0 and done follows with the normal latency.
  - done and err are never high together, and neither is ever high in two consecutive cycles.
  - j/k are 0 in IDLE and CHECK. They are non-zero only in DRIVE.

Decomposition:
- Shared package jk_pkg holds:
  - state encoding constants IDLE=2'd0, DRIVE=2'd1, CHECK=2'd2
  - mode constants MODE_SR=1'b0, MODE_TGL=1'b1
- Sub-module jk_excite is combinational, one bit wide, and is instantiated WIDTH times: (q, tq, mode) -> (j, k) per the table above.
- The FSM, latches and retry counter live in jk_bank_driver.

Test Plan:
- Bench setup: WIDTH=4 and MAX_RETRY=2, with four JK flip-flops on the same clk/rst as the bank model.
- Set/reset mode: bank=0000, start with target=1010, mode=0 -> DRIVE j=1010, k=0000; done one cycle after edge S+2; bank=1010; err never set.
- Toggle mode: bank=1100, target=0110, mode=1 -> j=k=1010 in DRIVE; bank=0110; done after 2 cycles.
- No change needed: bank=0101, target=0101 -> DRIVE j=k=0000; done with the 2-cycle latency; bank unchanged.
- Stuck bit: force bank bit0 to stay 0, target=0001 -> three DRIVE cycles (initial + 2 retries), each j=0001; err pulses once at edge S+6; done never set.
- Reset and busy handling:
  - Assert rst during DRIVE -> j/k/busy go to 0 asynchronously, no done/err.
  - After release, start target=1111 -> normal completion.
  - start pulses while busy are ignored: exactly one done.
